cdb_arbiter: RTL



---
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with registered broadcast
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
    parameter int N_REQ    = 4,
    parameter int FU_TAG_W = 3,
    parameter int RS_W     = 3,
    parameter int DATA_W   = 32,
    localparam int PAYLOAD_W = FU_TAG_W + RS_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*PAYLOAD_W-1:0] payload_in,
    output logic [PAYLOAD_W:0]         cdb,
    output logic [N_REQ-1:0]           grant,
    output logic [31:0]                stat_bcast,
    output logic [31:0]                stat_conflict
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PAYLOAD_W:0]   cdb_q, cdb_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]     elig;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PAYLOAD_W-1:0] pay_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign pay_arr[i] = payload_in[i*PAYLOAD_W +: PAYLOAD_W];
    end

    // The grant register doubles as the previous-winner mask.
    always_comb begin
        int idx;
        logic [PTR_W-1:0] cand;
        elig      = req & ~grant_q;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        cdb_d    = '0;
        grant_d  = '0;
        rr_ptr_d = rr_ptr_q;
        if (!flush && win_found) begin
            cdb_d            = {1'b1, pay_arr[win_idx]};
            grant_d[win_idx] = 1'b1;
            if (win_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb   = cdb_q;
    assign grant = grant_q;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] stat_bcast_q, stat_bcast_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        stat_bcast_d    = stat_bcast_q;
        stat_conflict_d = stat_conflict_q;
        if (!flush) begin
            if (win_found) begin
                stat_bcast_d = stat_bcast_q + 32'd1;
            end
            if ($countones(elig) >= 2) begin
                stat_conflict_d = stat_conflict_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bcast_q    <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_bcast_q    <= stat_bcast_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_bcast    = stat_bcast_q;
    assign stat_conflict = stat_conflict_q;
`else
    assign stat_bcast    = 32'd0;
    assign stat_conflict = 32'd0;
`endif

endmodule
